hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Pipeline sequencer for the 5-stage MIPS core. Sits beside the main decoder and drives write-enables/flushes of PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
//  Resolves load-use hazards, taken-branch (MEM stage) and jump (ID stage) flushes, and data-memory wait states.
//  A watchdog on the memory wait locks the pipeline in ERROR. A stall-cycle perf counter is kept.
// PARAMETERS
//  WAIT_TIMEOUT  15  max extra dmem wait cycles before ERROR; 0 disables the watchdog
//  CNT_W         16  width of stall_cycles perf counter
// PORTS
//  clk             in   1      clock, rising edge
//  rst             in   1      reset, asynchronous, active-high
//  id_rs, id_rt    in   5      source regs of instruction in ID
//  id_uses_rt      in   1      ID instruction reads rt (R-type, sw, beq)
//  id_jump         in   1      jump decoded in ID
//  ex_memread      in   1      instruction in EX is lw
//  ex_rt           in   5      destination reg of lw in EX
//  mem_req         in   1      MEM-stage instruction is lw/sw (MemRead|MemWrite)
//  dmem_ready      in   1      data memory completes access this cycle
//  mem_branch_taken in  1      beq in MEM resolved taken
//  pc_write, ifid_write, idex_write, exmem_write  out 1  register enables
//  ifid_flush, idex_flush, exmem_flush, memwb_flush out 1  zero control bits / insert nop
//  err             out  1      watchdog tripped (sticky)
//  stall_cycles    out  CNT_W  saturating count of stalled cycles
// BEHAVIOUR
//  State register {INIT, RUN, MEM_WAIT, ERROR} and counters are the only storage; the other outputs are combinational from state and inputs.
//  Reset: state=INIT, wait_cnt=0, stall_cycles=0.
//  INIT/ERROR outputs: all *_write=0, all *_flush=1. err=1 only in ERROR.
//  Transitions:
//  - INIT->RUN unconditionally on the next edge.
//  - RUN: if mem_req & !dmem_ready -> MEM_WAIT, wait_cnt<=1; else stay.
//  - MEM_WAIT: dmem_ready -> RUN, wait_cnt<=0.
//  - MEM_WAIT: else if WAIT_TIMEOUT!=0 & wait_cnt==WAIT_TIMEOUT -> ERROR.
//  - MEM_WAIT: else wait_cnt++.
//  - ERROR is left only by rst; all inputs are ignored.
//  Outputs in RUN/MEM_WAIT; the highest-priority condition applies and the rest default:
//  1 mem stall (mem_req & !dmem_ready): all four *_write=0, memwb_flush=1, other flushes 0.
//  2 mem_branch_taken: pc_write=1, ifid/idex/exmem_flush=1. A simultaneous load-use or jump is dropped, because its instruction is flushed.
//  3 load-use (ex_memread & ex_rt!=0 & (ex_rt==id_rs | id_uses_rt & ex_rt==id_rt)):
//    pc_write=0, ifid_write=0, idex_flush=1. Exactly 1 bubble, since the lw leaves EX next cycle.
//    A simultaneous id_jump is held and re-evaluated next cycle.
//  4 id_jump: pc_write=1, ifid_flush=1.
//  default: all writes 1, all flushes 0.
//  In MEM_WAIT with dmem_ready=1, the default/priority rules apply in that same cycle, so there is no extra dead cycle.
//  stall_cycles: +1 each RUN/MEM_WAIT cycle with pc_write=0; saturates at all-ones without wrapping.
//  wait_cnt width is clog2(WAIT_TIMEOUT+1), minimum 1.
//  ERROR is entered after WAIT_TIMEOUT+1 consecutive ready-low cycles.
//  Reset asserted mid-wait or in ERROR returns to INIT immediately, clearing the counters.
// TESTING
//  - Reset, release -> INIT 1 cycle (flushes=1, writes=0), then RUN with all writes 1.
//  - lw $5 in EX, ID reads rs=5 -> 1 cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cycles=1.
//  - ex_rt=0 or id_uses_rt=0 with rt match only -> no stall.
//  - Branch taken, load-use and jump in the same cycle -> flushes IF/ID/EX/MEM, pc_write=1, no bubble.
//  - mem_req, ready low 3 cycles -> 3 full stalls with memwb_flush=1, RUN on the 4th cycle; stall_cycles=3.
//  - WAIT_TIMEOUT=4, ready held low -> err=1 after 5 cycles, stays set; rst clears err and stall_cycles.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core: register enables and flushes for load-use,
// branch/jump redirects and data-memory wait states, with a wait watchdog and stall counter.
module hazard_stall_ctrl #(
   parameter int WAIT_TIMEOUT = 15,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_jump,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rt,
   input  logic             mem_req,
   input  logic             dmem_ready,
   input  logic             mem_branch_taken,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             idex_write,
   output logic             exmem_write,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             err,
   output logic [CNT_W-1:0] stall_cycles
);

   localparam int WAIT_W = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_TIMEOUT);
   localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

   typedef enum logic [1:0] {
      ST_INIT     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2,
      ST_ERROR    = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

   logic mem_stall;
   logic load_use;
   logic pipe_active;

   // Hazard detection; $zero never carries a real dependency
   always_comb begin
      mem_stall   = mem_req & ~dmem_ready;
      load_use    = ex_memread & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
      pipe_active = (state_q == ST_RUN) | (state_q == ST_MEM_WAIT);
   end

   always_comb begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      memwb_flush = 1'b0;
      err         = 1'b0;
      case (state_q)
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_stall) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_write  = 1'b0;
               exmem_write = 1'b0;
               memwb_flush = 1'b1;
            end else if (mem_branch_taken) begin
               // Younger load-use/jump instructions are squashed by this flush
               ifid_flush  = 1'b1;
               idex_flush  = 1'b1;
               exmem_flush = 1'b1;
            end else if (load_use) begin
               // A jump in ID is held here and redirects once the bubble is in
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_flush  = 1'b1;
            end else if (id_jump) begin
               ifid_flush  = 1'b1;
            end else begin
               pc_write    = 1'b1;
            end
         end
         ST_ERROR: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
            err         = 1'b1;
         end
         default: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            exmem_write = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      case (state_q)
         ST_INIT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (mem_stall) begin
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else begin
               state_d    = ST_RUN;
            end
         end
         ST_MEM_WAIT: begin
            if (dmem_ready) begin
               state_d    = ST_RUN;
               wait_cnt_d = WAIT_W'(0);
            end else if ((WAIT_TIMEOUT != 0) && (wait_cnt_q == WAIT_LIMIT)) begin
               state_d    = ST_ERROR;
            end else begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
         end
         ST_ERROR: begin
            state_d = ST_ERROR;
         end
         default: begin
            state_d    = ST_INIT;
            wait_cnt_d = WAIT_W'(0);
         end
      endcase
   end

   // Saturating count of cycles in which the PC was held
   always_comb begin
      if (pipe_active && !pc_write && (stall_cycles_q != CNT_MAX)) begin
         stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end else begin
         stall_cycles_d = stall_cycles_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_INIT;
         wait_cnt_q     <= WAIT_W'(0);
         stall_cycles_q <= CNT_W'(0);
      end else begin
         state_q        <= state_d;
         wait_cnt_q     <= wait_cnt_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Randomised and directed bench for hazard_stall_ctrl against a rule-level reference model.
module tb_hazard_stall_ctrl;

   localparam int TO  = 4;
   localparam int CW  = 4;
   localparam int CMAX = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [4:0] id_rs = 5'd0, id_rt = 5'd0, ex_rt = 5'd0;
   logic id_uses_rt = 1'b0, id_jump = 1'b0, ex_memread = 1'b0;
   logic mem_req = 1'b0, dmem_ready = 1'b1, mem_branch_taken = 1'b0;
   logic pc_write, ifid_write, idex_write, exmem_write;
   logic ifid_flush, idex_flush, exmem_flush, memwb_flush, err;
   logic [CW-1:0] stall_cycles;
   logic [8:0] out_vec, exp_v;

   int checks = 0;
   int errors = 0;
   int m_mode = 0;   // 0 init, 1 run, 2 waiting on memory, 3 error
   int m_wait = 0;
   int m_cnt  = 0;

   always #5 clk = ~clk;

   hazard_stall_ctrl #(.WAIT_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_jump(id_jump), .ex_memread(ex_memread), .ex_rt(ex_rt), .mem_req(mem_req),
      .dmem_ready(dmem_ready), .mem_branch_taken(mem_branch_taken),
      .pc_write(pc_write), .ifid_write(ifid_write), .idex_write(idex_write),
      .exmem_write(exmem_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .err(err),
      .stall_cycles(stall_cycles)
   );

   assign out_vec = {pc_write, ifid_write, idex_write, exmem_write,
                     ifid_flush, idex_flush, exmem_flush, memwb_flush, err};

   // {pc,ifid,idex,exmem writes, ifid,idex,exmem,memwb flushes, err}
   function automatic logic [8:0] ref_out();
      bit lu;
      if (m_mode == 0) return 9'b0000_1111_0;
      if (m_mode == 3) return 9'b0000_1111_1;
      lu = ex_memread && ex_rt != 5'd0 && (ex_rt == id_rs || (id_uses_rt && ex_rt == id_rt));
      if (mem_req && !dmem_ready) return 9'b0000_0001_0;
      if (mem_branch_taken)       return 9'b1111_1110_0;
      if (lu)                     return 9'b0011_0100_0;
      if (id_jump)                return 9'b1111_1000_0;
      return 9'b1111_0000_0;
   endfunction

   task automatic ref_advance();
      logic [8:0] o;
      o = ref_out();
      if ((m_mode == 1 || m_mode == 2) && !o[8] && m_cnt < CMAX) m_cnt++;
      case (m_mode)
         0: m_mode = 1;
         1: if (mem_req && !dmem_ready) begin m_mode = 2; m_wait = 1; end
         2: if (dmem_ready) begin m_mode = 1; m_wait = 0; end
            else if (m_wait == TO) m_mode = 3;
            else m_wait++;
         default: m_mode = 3;
      endcase
   endtask

   task automatic ref_reset();
      m_mode = 0; m_wait = 0; m_cnt = 0;
   endtask

   task automatic drive(input int rs, input int rt, input bit uses, input bit jmp,
                        input bit mrd, input int ert, input bit req, input bit rdy, input bit br);
      id_rs = 5'(rs); id_rt = 5'(rt); id_uses_rt = uses; id_jump = jmp;
      ex_memread = mrd; ex_rt = 5'(ert); mem_req = req; dmem_ready = rdy; mem_branch_taken = br;
   endtask

   task automatic idle();
      drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b1;
      ref_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (out_vec !== 9'b0000_1111_0 || stall_cycles !== 4'd0) begin
         errors++;
         $display("FAIL reset_hold out=%b cnt=%0d want=000011110 cnt=0", out_vec, stall_cycles);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         exp_v = ref_out();
         checks++;
         if (out_vec !== exp_v || stall_cycles !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL reset_release[%0d] out=%b cnt=%0d want=%b cnt=%0d", i, out_vec, stall_cycles, exp_v, m_cnt);
         end
         ref_advance();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_load_use();
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: drive(5, 7, 1'b0, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);   // rs match
            1: drive(0, 0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0);   // $zero, no stall
            2: drive(3, 9, 1'b0, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0);   // rt match, rt unused
            3: drive(3, 9, 1'b1, 1'b0, 1'b1, 9, 1'b0, 1'b1, 1'b0);   // rt match, used
            4: drive(5, 5, 1'b1, 1'b0, 1'b0, 5, 1'b0, 1'b1, 1'b0);   // not a load
            default: idle();
         endcase
         @(negedge clk);
         exp_v = ref_out();
         checks++;
         if (out_vec !== exp_v || stall_cycles !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL load_use[%0d] out=%b cnt=%0d want=%b cnt=%0d", i, out_vec, stall_cycles, exp_v, m_cnt);
         end
         ref_advance();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: drive(6, 0, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b1);   // branch+lu+jump
            1: drive(6, 0, 1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b1, 1'b0);   // lu holds jump
            2: drive(6, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b0);   // jump taken
            3: drive(6, 0, 1'b0, 1'b1, 1'b1, 6, 1'b1, 1'b0, 1'b1);   // mem stall beats all
            default: idle();
         endcase
         @(negedge clk);
         exp_v = ref_out();
         checks++;
         if (out_vec !== exp_v || stall_cycles !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL combo[%0d] out=%b cnt=%0d want=%b cnt=%0d", i, out_vec, stall_cycles, exp_v, m_cnt);
         end
         ref_advance();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mem_wait();
      rst = 1'b1; ref_reset(); idle();
      @(posedge clk); #1; rst = 1'b0;
      for (int i = 0; i < 7; i++) begin
         if (i == 0) idle();
         else if (i < 4) drive(1, 2, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
         else if (i == 4) drive(1, 2, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b1, 1'b0);
         else idle();
         @(negedge clk);
         exp_v = ref_out();
         checks++;
         if (out_vec !== exp_v || stall_cycles !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL mem_wait[%0d] out=%b cnt=%0d want=%b cnt=%0d", i, out_vec, stall_cycles, exp_v, m_cnt);
         end
         ref_advance();
         @(posedge clk); #1;
      end
      checks++;
      if (stall_cycles !== 4'd3) begin
         errors++;
         $display("FAIL mem_wait_total cnt=%0d want=3", stall_cycles);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         if (i % 100 == 0) begin
            rst = 1'b1; ref_reset();
            @(posedge clk); #1; rst = 1'b0;
         end
         drive($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               1'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 2) == 0),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) == 0));
         @(negedge clk);
         exp_v = ref_out();
         checks++;
         if (out_vec !== exp_v || stall_cycles !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL random[%0d] out=%b cnt=%0d want=%b cnt=%0d", i, out_vec, stall_cycles, exp_v, m_cnt);
         end
         ref_advance();
         @(posedge clk); #1;
      end
   endtask

   task automatic test_watchdog();
      rst = 1'b1; ref_reset(); idle();
      @(posedge clk); #1; rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (i == 0) idle();
         else if (i < 7) drive(0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0);
         else drive(0, 0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 1'b1);   // ignored in error
         @(negedge clk);
         exp_v = ref_out();
         checks++;
         if (out_vec !== exp_v || stall_cycles !== CW'(m_cnt)) begin
            errors++;
            $display("FAIL watchdog[%0d] out=%b cnt=%0d want=%b cnt=%0d", i, out_vec, stall_cycles, exp_v, m_cnt);
         end
         ref_advance();
         @(posedge clk); #1;
      end
      checks++;
      if (err !== 1'b1 || stall_cycles !== 4'd5) begin
         errors++;
         $display("FAIL watchdog_sticky err=%b cnt=%0d want err=1 cnt=5", err, stall_cycles);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (err !== 1'b0 || stall_cycles !== 4'd0 || out_vec !== 9'b0000_1111_0) begin
         errors++;
         $display("FAIL async_reset err=%b cnt=%0d out=%b want err=0 cnt=0 out=000011110", err, stall_cycles, out_vec);
      end
      ref_reset();
      @(posedge clk); #1; rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_back_to_back();
      test_mem_wait();
      test_random();
      test_watchdog();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
